// File: rtl/pacman_pkg.sv
// Shared types for the sprite line scheduler: sprite ids, ROM image selectors,
// the per-line sprite entry and the scan FSM states.
package pacman_pkg;

    typedef enum logic [1:0] {SPR_PAC, SPR_RED, SPR_GREEN, SPR_AQUA} spr_id_t;

    localparam logic [1:0] IMG_PAC_RIGHT = 2'd0;
    localparam logic [1:0] IMG_PAC_UP    = 2'd1;
    localparam logic [1:0] IMG_GHOST     = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [7:0] bits;
    } spr_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_REQ, ST_WAIT, ST_STORE, ST_DONE
    } sched_state_t;

    // Left-right flip of a sprite row (pacman facing left reuses the right image).
    function automatic logic [7:0] mirror8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction

endpackage

// File: rtl/sprite_row_hit.sv
// One sprite's lit test for the current beam X against a stored 8-pixel row.
module sprite_row_hit
    import pacman_pkg::*;
(
    input  spr_entry_t entry,
    input  logic [9:0] DrawX,
    output logic       lit
);

    logic [9:0] dx;

    // Unsigned difference: beam left of the sprite wraps to a large value and misses.
    assign dx  = DrawX - entry.x;
    assign lit = entry.valid && (dx < 10'd8) && entry.bits[3'd7 - dx[2:0]];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Fetches next-line sprite rows through one ROM port during horizontal blank and
// resolves per-pixel sprite priority from the committed line buffer.
module sprite_line_scheduler
    import pacman_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int SPR_SIZE = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] sprX [4],
    input  logic [9:0] sprY [4],
    input  logic [1:0] last_keypress,
    input  logic       isDefeated,
    output logic [4:0] rom_addr,
    output logic       rom_req,
    input  logic [7:0] rom_data,
    output logic       pix_on,
    output logic [1:0] pix_id,
    output logic       overrun
);

    localparam logic [9:0] X_SCAN   = 10'(H_ACTIVE);
    localparam logic [9:0] X_COMMIT = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] SZ       = 10'(SPR_SIZE);

    sched_state_t state, state_nx;
    logic [1:0]   idx;
    logic [9:0]   y_next;
    logic [9:0]   x_lat;
    logic         mirror_lat;
    spr_entry_t   shadow [4];
    spr_entry_t   active [4];

    logic [9:0]   dy_cur;
    logic [2:0]   row;
    logic         hit;
    logic [4:0]   addr_nx;
    logic [3:0]   lit;
    spr_id_t      win;

    assign dy_cur  = y_next - sprY[idx];
    assign row     = dy_cur[2:0];
    assign hit     = (dy_cur < SZ) && !((idx == 2'd0) && isDefeated);
    assign rom_req = (state == ST_REQ);

    always_comb begin
        addr_nx = {IMG_GHOST, row};
        if (idx == 2'd0) begin
            case (last_keypress)
                2'd3:    addr_nx = {IMG_PAC_UP, row};
                2'd1:    addr_nx = {IMG_PAC_UP, 3'd7 - row};
                default: addr_nx = {IMG_PAC_RIGHT, row};
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (DrawX == X_SCAN) state_nx = ST_CHECK;
            ST_CHECK: if (hit)              state_nx = ST_REQ;
                      else if (idx == 2'd3) state_nx = ST_DONE;
            ST_REQ:   state_nx = ST_WAIT;
            ST_WAIT:  state_nx = ST_STORE;
            ST_STORE: state_nx = (idx == 2'd3) ? ST_DONE : ST_CHECK;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx        <= 2'd0;
            y_next     <= 10'd0;
            x_lat      <= 10'd0;
            mirror_lat <= 1'b0;
            rom_addr   <= 5'd0;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: if (DrawX == X_SCAN) begin
                    y_next <= (DrawY == Y_LAST) ? 10'd0 : DrawY + 10'd1;
                    idx    <= 2'd0;
                    for (int i = 0; i < 4; i++) shadow[i].valid <= 1'b0;
                end
                ST_CHECK: begin
                    if (hit) begin
                        rom_addr   <= addr_nx;
                        x_lat      <= sprX[idx];
                        mirror_lat <= (idx == 2'd0) && (last_keypress == 2'd2);
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                ST_STORE: begin
                    shadow[idx] <= spr_entry_t'{valid: 1'b1, x: x_lat,
                                   bits: mirror_lat ? mirror8(rom_data) : rom_data};
                    idx         <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_hit
        sprite_row_hit u_hit (
            .entry (active[g]),
            .DrawX (DrawX),
            .lit   (lit[g])
        );
    end

    always_comb begin
        win = SPR_PAC;
        if (lit[3]) win = SPR_AQUA;
        if (lit[2]) win = SPR_GREEN;
        if (lit[1]) win = SPR_RED;
        if (lit[0]) win = SPR_PAC;
    end

    // Line commit and registered pixel output; blank-region pixels never light.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 4; i++) active[i] <= '0;
            overrun <= 1'b0;
            pix_on  <= 1'b0;
            pix_id  <= 2'd0;
        end else begin
            if (DrawX == X_COMMIT) begin
                for (int i = 0; i < 4; i++) active[i] <= shadow[i];
                if (state != ST_IDLE) overrun <= 1'b1;
            end
            pix_on <= (|lit) && (DrawX < X_SCAN);
            pix_id <= ((|lit) && (DrawX < X_SCAN)) ? win : SPR_PAC;
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench: drives the beam line by line, models a 1-cycle sprite ROM,
// and checks fetch strobes and per-pixel sprite output against hand-computed values.
module tb_sprite_line_scheduler;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic [9:0] sprX [4];
    logic [9:0] sprY [4];
    logic [1:0] last_keypress = 2'd0;
    logic       isDefeated = 1'b0;
    logic [4:0] rom_addr;
    logic       rom_req;
    logic [7:0] rom_data = 8'd0;
    logic       pix_on;
    logic [1:0] pix_id;
    logic       overrun;

    logic [7:0] rom [32];

    logic       pix_a  [800];
    logic [1:0] id_a   [800];
    logic       req_a  [800];
    logic [4:0] addr_a [800];

    int n_checks = 0;
    int n_fail   = 0;

    sprite_line_scheduler dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .sprX          (sprX),
        .sprY          (sprY),
        .last_keypress (last_keypress),
        .isDefeated    (isDefeated),
        .rom_addr      (rom_addr),
        .rom_req       (rom_req),
        .rom_data      (rom_data),
        .pix_on        (pix_on),
        .pix_id        (pix_id),
        .overrun       (overrun)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM: registered read, data valid the cycle after the strobe.
    always @(posedge Clk) if (rom_req) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge Clk);
        #1;
        pix_a[x]  = pix_on;
        id_a[x]   = pix_id;
        req_a[x]  = rom_req;
        addr_a[x] = rom_addr;
    endtask

    task automatic run_line(input int y);
        for (int x = 0; x < 800; x++) tick(x, y);
    endtask

    function automatic int req_count();
        int n = 0;
        for (int x = 0; x < 800; x++) if (req_a[x]) n++;
        return n;
    endfunction

    task automatic span(input string tag, input int lo, input int hi,
                        input logic on, input logic [1:0] id);
        for (int x = lo; x <= hi; x++) begin
            chk($sformatf("%s_on@%0d", tag, x), 32'(pix_a[x]), 32'(on));
            chk($sformatf("%s_id@%0d", tag, x), 32'(id_a[x]), 32'(id));
        end
    endtask

    task automatic park();
        for (int i = 0; i < 4; i++) begin
            sprX[i] = 10'd0;
            sprY[i] = 10'd1000;
        end
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    initial begin
        int lit_cnt;
        park();
        fill_rom(8'h00);

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_rom_req", 32'(rom_req), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_pix_on", 32'(pix_on), 32'd0);
        chk("rst_pix_id", 32'(pix_id), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        Reset_n = 1'b1;

        // Pacman facing right, row 3 = F0
        rom[3] = 8'hF0;
        sprX[0] = 10'd100;
        sprY[0] = 10'd50;
        run_line(52);
        chk("t1_req_count", 32'(req_count()), 32'd1);
        chk("t1_req_641", 32'(req_a[641]), 32'd1);
        chk("t1_addr", 32'(addr_a[641]), 32'd3);
        run_line(53);
        span("t1_lit", 100, 103, 1'b1, 2'd0);
        span("t1_dark", 104, 107, 1'b0, 2'd0);
        chk("t1_left", 32'(pix_a[99]), 32'd0);

        // Facing left: mirrored row
        last_keypress = 2'd2;
        run_line(52);
        run_line(53);
        span("t2_dark", 100, 103, 1'b0, 2'd0);
        span("t2_lit", 104, 107, 1'b1, 2'd0);

        // Facing down: flipped row index on the up image
        last_keypress = 2'd1;
        run_line(52);
        chk("t2_addr_down", 32'(addr_a[641]), 32'h0C);

        // Pacman over red ghost, priority and defeat
        last_keypress = 2'd0;
        fill_rom(8'hFF);
        sprX[0] = 10'd200; sprY[0] = 10'd200;
        sprX[1] = 10'd200; sprY[1] = 10'd200;
        run_line(199);
        chk("t3_req_count", 32'(req_count()), 32'd2);
        run_line(200);
        span("t3_pac", 200, 207, 1'b1, 2'd0);
        chk("t3_right", 32'(pix_a[208]), 32'd0);
        isDefeated = 1'b1;
        run_line(199);
        chk("t3_def_req_count", 32'(req_count()), 32'd1);
        run_line(200);
        span("t3_red", 200, 207, 1'b1, 2'd1);

        // All four sprites on one line
        isDefeated = 1'b0;
        for (int i = 0; i < 4; i++) sprY[i] = 10'd300;
        sprX[0] = 10'd10; sprX[1] = 10'd30; sprX[2] = 10'd50; sprX[3] = 10'd70;
        run_line(299);
        chk("t4_req_count", 32'(req_count()), 32'd4);
        chk("t4_req_641", 32'(req_a[641]), 32'd1);
        chk("t4_req_645", 32'(req_a[645]), 32'd1);
        chk("t4_req_649", 32'(req_a[649]), 32'd1);
        chk("t4_req_653", 32'(req_a[653]), 32'd1);
        chk("t4_addr_pac", 32'(addr_a[641]), 32'h00);
        chk("t4_addr_red", 32'(addr_a[645]), 32'h10);
        chk("t4_overrun", 32'(overrun), 32'd0);
        run_line(300);
        span("t4_pac", 10, 17, 1'b1, 2'd0);
        chk("t4_gap", 32'(pix_a[18]), 32'd0);
        span("t4_red", 30, 37, 1'b1, 2'd1);
        span("t4_green", 50, 57, 1'b1, 2'd2);
        span("t4_aqua", 70, 77, 1'b1, 2'd3);

        // Frame wrap and right-edge clip
        park();
        sprX[3] = 10'd636;
        sprY[3] = 10'd0;
        run_line(524);
        chk("t5_req_count", 32'(req_count()), 32'd1);
        run_line(0);
        span("t5_lit", 636, 639, 1'b1, 2'd3);
        span("t5_clip", 640, 643, 1'b0, 2'd0);
        span("t5_nowrap", 0, 3, 1'b0, 2'd0);

        // Commit reached mid-scan
        park();
        sprX[0] = 10'd100;
        sprY[0] = 10'd50;
        tick(640, 52);
        tick(641, 52);
        tick(799, 52);
        chk("ovr_set", 32'(overrun), 32'd1);
        run_line(53);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset while waiting on the ROM
        for (int x = 0; x <= 642; x++) tick(x, 52);
        chk("t6_req_before", 32'(req_a[641]), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("t6_rom_req", 32'(rom_req), 32'd0);
        chk("t6_rom_addr", 32'(rom_addr), 32'd0);
        chk("t6_pix_on", 32'(pix_on), 32'd0);
        chk("t6_pix_id", 32'(pix_id), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);
        #3;
        Reset_n = 1'b1;
        for (int x = 643; x < 800; x++) tick(x, 52);
        run_line(53);
        lit_cnt = 0;
        for (int x = 0; x < 800; x++) if (pix_a[x]) lit_cnt++;
        chk("t6_empty_line", 32'(lit_cnt), 32'd0);
        chk("t6_rescan_req", 32'(req_count()), 32'd1);
        run_line(54);
        span("t6_resume", 100, 107, 1'b1, 2'd0);
        chk("t6_overrun_after", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
